// File: rtl/seq_mod3_encoder.sv
// Serial mod-3 frame encoder.
// Accepts a DATA_W-bit payload over valid/ready and shifts it out MSB-first on
// `data`, followed by two check bits. The check bits make every frame value
// (payload*4 + check) divisible by 3. Idle bits are 0.
module seq_mod3_encoder #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              tx_en,
  output logic              data,
  output logic              data_valid,
  output logic              frame_start,
  output logic              frame_end
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CHK0,
    S_CHK1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        res_q, res_d;
  logic              data_d, data_valid_d, frame_start_d, frame_end_d;
  logic              capture;

  // Residue of (2r + b) mod 3 for r in 0..2; the result never reaches 3.
  function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
    case (r)
      2'd0:    return {1'b0, b};
      2'd1:    return b ? 2'd0 : 2'd2;
      default: return b ? 2'd2 : 2'd1;
    endcase
  endfunction

  // Ready while idle (independent of tx_en) or while the final check bit
  // leaves on an advancing edge, which lets frames run back to back.
  always_comb begin
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_CHK1:  in_ready = tx_en;
      default: in_ready = 1'b0;
    endcase
  end

  assign capture = in_valid & in_ready;

  // Next-state and next-output logic; everything holds unless captured or advanced.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    res_d         = res_q;
    data_d        = data;
    data_valid_d  = data_valid;
    frame_start_d = frame_start;
    frame_end_d   = frame_end;

    if (capture) begin
      state_d       = S_DATA;
      shreg_d       = in_data;
      cnt_d         = CW'(DATA_W - 1);
      res_d         = {1'b0, in_data[DATA_W-1]};
      data_d        = in_data[DATA_W-1];
      data_valid_d  = 1'b1;
      frame_start_d = 1'b1;
      frame_end_d   = 1'b0;
    end else if (tx_en) begin
      case (state_q)
        S_DATA: begin
          frame_start_d = 1'b0;
          if (cnt_q == '0) begin
            // res_q already covers the LSB: check = (3 - r) mod 3, MSB first.
            state_d = S_CHK0;
            data_d  = (res_q == 2'd1);
          end else begin
            // The register shifts left so the next bit is always at DATA_W-2.
            cnt_d   = cnt_q - CW'(1);
            shreg_d = shreg_q << 1;
            data_d  = shreg_q[DATA_W-2];
            res_d   = res_step(res_q, shreg_q[DATA_W-2]);
          end
        end
        S_CHK0: begin
          state_d     = S_CHK1;
          data_d      = (res_q == 2'd2);
          frame_end_d = 1'b1;
        end
        S_CHK1: begin
          state_d      = S_IDLE;
          data_d       = 1'b0;
          data_valid_d = 1'b0;
          frame_end_d  = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // State, payload, residue and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      data        <= 1'b0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      data        <= data_d;
      data_valid  <= data_valid_d;
      frame_start <= frame_start_d;
      frame_end   <= frame_end_d;
    end
  end

endmodule

// File: doc/seq_mod3_encoder.md
Name: seq_mod3_encoder

Overview:
Serial transmitter for the mod-3 bit-stream protocol that `seq_mod3_detector` receives. It accepts a parallel word over a valid/ready handshake. It then shifts the word out MSB-first on `data`, followed by 2 check bits chosen so that each frame's value is divisible by 3. Idle bits are 0, and every frame is ≡0 mod 3. As a result, the detector's accumulated stream value is ≡0 mod 3 at every frame end. The block sits upstream of the detector and doubles as its self-checking stimulus source.

Parameters:
DATA_W, 8, payload width in bits (≥2); frame length is DATA_W+2 bits.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  reset.
in_valid  in  1  payload word offered.
in_data  in  DATA_W  payload word; captured when in_valid & in_ready.
in_ready  out  1  encoder can accept a word this cycle (combinational from state and tx_en).
tx_en  in  1  advance enable; low = stall, all state and outputs hold.
data  out  1  serial bit to detector, registered.
data_valid  out  1  high while `data` carries a frame bit, registered.
frame_start  out  1  high with the first (MSB) bit of a frame, registered.
frame_end  out  1  high with the last check bit of a frame, registered.

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state IDLE; data=0, data_valid=0, frame_start=0, frame_end=0.
  - bit counter=0, residue=0.
  - in_ready=1 after release.
- States:
  - IDLE: data=0, data_valid=0.
  - DATA: DATA_W bits, counter counts DATA_W-1..0.
  - CHK0: check bit 1 (MSB of check).
  - CHK1: check bit 0.
- in_ready:
  - In IDLE, in_ready=1 regardless of tx_en; capture is not gated by tx_en.
  - In CHK1, in_ready = tx_en.
  - In DATA and CHK0, in_ready=0.
- Capture edge (in_valid & in_ready):
  - Shift register loads in_data; state goes to DATA.
  - data <= in_data[DATA_W-1]; data_valid<=1; frame_start<=1.
  - Residue r <= in_data[DATA_W-1].
- Stall: any edge with tx_en=0 in DATA/CHK0/CHK1 changes nothing.
- Advance edge (tx_en=1), DATA:
  - Next bit is shifted out MSB-first; r <= (2r+bit) mod 3.
  - frame_start<=0.
  - After the LSB has been presented, go to CHK0.
- Check bits from final residue r over all DATA_W bits:
  - r=0 → 00; r=1 → 10; r=2 → 01.
  - Net effect: check = (3-r) mod 3, so (payload*4 + check) mod 3 = 0.
- CHK0 → CHK1 on advance; frame_end<=1 together with the CHK1 bit.
- Leaving CHK1 on advance:
  - If in_valid, new frame starts with zero bubble (capture edge as above; frame_end<=0, frame_start<=1).
  - Else → IDLE with data=0, data_valid=0, frame_end=0.
- Latency and length:
  - First bit appears on `data` the cycle after the capture edge.
  - Unstalled frame occupies exactly DATA_W+2 consecutive cycles.
- Residue is 2 bits, values 0..2 only; 3 is never stored.
- Reset mid-frame: immediate abort to IDLE, outputs to reset values. A partial frame is not resumed; the downstream detector must be reset too.
- in_data changes while not captured are ignored. The payload is stable internally once captured.

Test Plan:
- DATA_W=8, reset, send 0x05, tx_en=1 → data=0000_0101_01 over 10 cycles (value 21). frame_start on cycle 1, frame_end on cycle 10, detector success after last bit.
- Send 0x01 then 0xFF back-to-back with in_valid held → 0000_0001_10 immediately followed by 1111_1111_00 (0 mod 3). 20 contiguous data_valid cycles; in_ready high only in the CHK1 cycle of frame 1.
- Send 0x02 (r=2), drop tx_en for 3 cycles during bit 4 → data/data_valid frozen 3 cycles. Output stays 0000_0010_01 (9), frame length 13 cycles.
- Idle gaps: 0x07, 5 idle cycles, 0x0B → idle data=0, data_valid=0. Detector success after each frame end and during gaps; checks 10 and 01.
- Assert rst_n=0 asynchronously mid-bit 5 of 0xAA → outputs 0 immediately without clock edge; in_ready=1 after release. Next frame 0x03 encodes correctly as 0000_0011_00.
- Random 200 words → every frame value mod 3 = 0; concatenated stream mod 3 = 0 at each frame_end.
